// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for pipeline_ctrl: operand-forward selects, memory-wait states and per-stage metadata.
// Used by both the default build and the PIPELINE_CTRL_PERF_EN build.
package pipeline_ctrl_pkg;

    // Register indices are carried at this fixed width; REG_ADDR_W must not exceed it.
    localparam int META_ADDR_W = 8;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    typedef enum logic [1:0] {
        CS_RUN   = 2'b00,
        CS_WAIT  = 2'b01,
        CS_ERROR = 2'b10
    } ctrl_state_t;

    typedef struct packed {
        logic                   valid;
        logic                   regwrite;
        logic                   memread;
        logic [META_ADDR_W-1:0] rd;
        logic [META_ADDR_W-1:0] rs1;
        logic [META_ADDR_W-1:0] rs2;
    } stage_meta_t;

    localparam int META_W = $bits(stage_meta_t);

    // True when stage m will write a non-zero register that matches src.
    function automatic logic writesReg(input stage_meta_t m, input logic [META_ADDR_W-1:0] src);
        return m.valid && m.regwrite && (m.rd != '0) && (m.rd == src);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_meta_stage.sv
// One pipeline metadata register: clear wins over enable, otherwise holds.
module pipe_meta_stage
    import pipeline_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_en,
    input  logic              i_clr,
    input  logic [META_W-1:0] i_d,
    output logic [META_W-1:0] o_q
);

    logic [META_W-1:0] r_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard controller for a D/E/M/W pipeline: forwarding, load-use and memory-wait stalls, branch flushes.
// Defining PIPELINE_CTRL_PERF_EN adds saturating stall/flush/retire counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_d,
    input  logic [REG_ADDR_W-1:0] rs1_d,
    input  logic [REG_ADDR_W-1:0] rs2_d,
    input  logic [REG_ADDR_W-1:0] rd_d,
    input  logic                  regwrite_d,
    input  logic                  memread_d,
    input  logic                  branch_taken_e,
    input  logic                  mem_req_m,
    input  logic                  mem_ready,
    output logic [1:0]            forward_a_e,
    output logic [1:0]            forward_b_e,
    output logic                  stall_f,
    output logic                  stall_d,
    output logic                  stall_e,
    output logic                  stall_m,
    output logic                  flush_d,
    output logic                  flush_e,
    output logic                  valid_w,
    output logic                  mem_err
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic [CNT_W-1:0]      retired_count
`endif
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    ctrl_state_t       r_state;
    logic [WCNT_W-1:0] r_waitCnt;
    logic              r_memErr;

    stage_meta_t w_dMeta;
    stage_meta_t w_eStage;
    stage_meta_t w_mStage;
    stage_meta_t w_wStage;
    fwd_sel_t    w_fwdA;
    fwd_sel_t    w_fwdB;
    logic        w_branch;
    logic        w_lwRaw;
    logic        w_lwstall;
    logic        w_memstall;
    logic        w_hold;
    logic        w_flushE;
    logic        w_unusedMeta;

    always_comb begin
        w_dMeta          = '0;
        w_dMeta.valid    = valid_d;
        w_dMeta.regwrite = regwrite_d;
        w_dMeta.memread  = memread_d;
        w_dMeta.rd       = META_ADDR_W'(rd_d);
        w_dMeta.rs1      = META_ADDR_W'(rs1_d);
        w_dMeta.rs2      = META_ADDR_W'(rs2_d);
    end

    // The ready cycle is not a stall, so M drains on the edge that completes the access.
    assign w_memstall = ((r_state == CS_WAIT) && !mem_ready) ||
                        ((r_state == CS_RUN) && w_mStage.valid && mem_req_m && !mem_ready);
    assign w_hold     = w_memstall || (r_state == CS_ERROR);

    assign w_branch  = branch_taken_e && w_eStage.valid;
    assign w_lwRaw   = w_eStage.valid && w_eStage.memread && (w_eStage.rd != '0) && valid_d &&
                       ((w_eStage.rd == w_dMeta.rs1) || (w_eStage.rd == w_dMeta.rs2));
    assign w_lwstall = w_lwRaw && !w_branch;
    assign w_flushE  = (w_branch || w_lwstall) && !w_hold;

    assign stall_f = w_hold || w_lwstall;
    assign stall_d = w_hold || w_lwstall;
    assign stall_e = w_hold;
    assign stall_m = w_hold;
    assign flush_d = w_branch && !w_hold;
    assign flush_e = w_flushE;
    assign valid_w = w_wStage.valid;
    assign mem_err = r_memErr;

    always_comb begin
        w_fwdA = FWD_RF;
        w_fwdB = FWD_RF;
        if (writesReg(w_mStage, w_eStage.rs1)) begin
            w_fwdA = FWD_M;
        end else if (writesReg(w_wStage, w_eStage.rs1)) begin
            w_fwdA = FWD_W;
        end
        if (writesReg(w_mStage, w_eStage.rs2)) begin
            w_fwdB = FWD_M;
        end else if (writesReg(w_wStage, w_eStage.rs2)) begin
            w_fwdB = FWD_W;
        end
    end

    assign forward_a_e = w_fwdA;
    assign forward_b_e = w_fwdB;

    pipe_meta_stage u_stageE (
        .clk   (clk),
        .reset (reset),
        .i_en  (!w_hold),
        .i_clr (w_flushE),
        .i_d   (w_dMeta),
        .o_q   (w_eStage)
    );

    pipe_meta_stage u_stageM (
        .clk   (clk),
        .reset (reset),
        .i_en  (!w_hold),
        .i_clr (1'b0),
        .i_d   (w_eStage),
        .o_q   (w_mStage)
    );

    pipe_meta_stage u_stageW (
        .clk   (clk),
        .reset (reset),
        .i_en  (1'b1),
        .i_clr (w_hold),
        .i_d   (w_mStage),
        .o_q   (w_wStage)
    );

    // ERROR is terminal; only reset returns the controller to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= CS_RUN;
            r_waitCnt <= '0;
            r_memErr  <= 1'b0;
        end else begin
            case (r_state)
                CS_RUN: begin
                    if (w_mStage.valid && mem_req_m && !mem_ready) begin
                        r_state   <= CS_WAIT;
                        r_waitCnt <= '0;
                    end
                end
                CS_WAIT: begin
                    if (mem_ready) begin
                        r_state   <= CS_RUN;
                        r_waitCnt <= '0;
                    end else if (r_waitCnt == WAIT_LAST) begin
                        r_state   <= CS_ERROR;
                        r_waitCnt <= r_waitCnt + 1'b1;
                        r_memErr  <= 1'b1;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                CS_ERROR: begin
                    r_state <= CS_ERROR;
                end
                default: begin
                    r_state <= CS_RUN;
                end
            endcase
        end
    end

    assign w_unusedMeta = ^{w_wStage.rs1, w_wStage.rs2, w_wStage.memread};

`ifdef PIPELINE_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stallCycles;
    logic [CNT_W-1:0] r_flushCount;
    logic [CNT_W-1:0] r_retiredCount;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stallCycles  <= '0;
            r_flushCount   <= '0;
            r_retiredCount <= '0;
        end else begin
            if ((w_lwstall || w_memstall) && (r_stallCycles != '1)) begin
                r_stallCycles <= r_stallCycles + 1'b1;
            end
            if (w_flushE && w_branch && (r_flushCount != '1)) begin
                r_flushCount <= r_flushCount + 1'b1;
            end
            if (w_wStage.valid && (r_retiredCount != '1)) begin
                r_retiredCount <= r_retiredCount + 1'b1;
            end
        end
    end

    assign stall_cycles  = r_stallCycles;
    assign flush_count   = r_flushCount;
    assign retired_count = r_retiredCount;
`else
    localparam int unusedCntW = CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl (MEM_TIMEOUT=4): forwarding, load-use, branch flush, memory wait, timeout, reset.
module tb_pipeline_ctrl;

    logic       clk;
    logic       reset;
    logic       valid_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_d;
    logic       regwrite_d;
    logic       memread_d;
    logic       branch_taken_e;
    logic       mem_req_m;
    logic       mem_ready;
    logic [1:0] forward_a_e;
    logic [1:0] forward_b_e;
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       stall_m;
    logic       flush_d;
    logic       flush_e;
    logic       valid_w;
    logic       mem_err;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    logic [31:0] retired_count;
`endif

    int errors;
    int checks;

    logic [10:0] outVec;
    logic [3:0]  stallVec;
    assign outVec   = {forward_a_e, forward_b_e, stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, valid_w};
    assign stallVec = {stall_f, stall_d, stall_e, stall_m};

    pipeline_ctrl #(
        .REG_ADDR_W  (5),
        .MEM_TIMEOUT (4),
        .CNT_W       (32)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .valid_d        (valid_d),
        .rs1_d          (rs1_d),
        .rs2_d          (rs2_d),
        .rd_d           (rd_d),
        .regwrite_d     (regwrite_d),
        .memread_d      (memread_d),
        .branch_taken_e (branch_taken_e),
        .mem_req_m      (mem_req_m),
        .mem_ready      (mem_ready),
        .forward_a_e    (forward_a_e),
        .forward_b_e    (forward_b_e),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .stall_e        (stall_e),
        .stall_m        (stall_m),
        .flush_d        (flush_d),
        .flush_e        (flush_e),
        .valid_w        (valid_w),
        .mem_err        (mem_err)
`ifdef PIPELINE_CTRL_PERF_EN
        ,
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count),
        .retired_count  (retired_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] rd, input logic rw, input logic mr,
                                 input logic br, input logic req, input logic rdy);
        valid_d        = v;
        rs1_d          = rs1;
        rs2_d          = rs2;
        rd_d           = rd;
        regwrite_d     = rw;
        memread_d      = mr;
        branch_taken_e = br;
        mem_req_m      = req;
        mem_ready      = rdy;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            nextCycle();
            applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic applyIdleWithMem(input logic br, input logic req, input logic rdy);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, br, req, rdy);
    endtask

    initial begin
        errors = 0;
        checks = 0;

        // Reset with hostile inputs: outputs must stay zero regardless of clock edges.
        reset = 1'b0;
        applyStimulus(1'b1, 5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        #2;
        checkOutput("reset_outputs", 32'(outVec), 32'd0);
        checkOutput("reset_mem_err", 32'(mem_err), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_held_outputs", 32'(outVec), 32'd0);
`ifdef PIPELINE_CTRL_PERF_EN
        checkOutput("reset_perf", stall_cycles | flush_count | retired_count, 32'd0);
`endif
        @(negedge clk);
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        nextCycle();
        checkOutput("first_cycle_outputs", 32'(outVec), 32'd0);
        checkOutput("first_cycle_mem_err", 32'(mem_err), 32'd0);

        // Forwarding: I1 add x5, I2 rs1=5, I3 rs2=5 rd=0, I4 rd=5, I5 rd=5, I6 rs1=rs2=5.
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("fwd_a_from_m", 32'(forward_a_e), 32'd2);
        checkOutput("fwd_b_none", 32'(forward_b_e), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("fwd_b_from_w", 32'(forward_b_e), 32'd1);
        checkOutput("valid_w_commit", 32'(valid_w), 32'd1);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("fwd_a_rd0", 32'(forward_a_e), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 5'd5, 5'd5, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("fwd_a_m_priority", 32'(forward_a_e), 32'd2);
        checkOutput("fwd_b_m_priority", 32'(forward_b_e), 32'd2);
        idleCycles(3);

        // Load-use: load x7 then a consumer of x7 on rs2.
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lw_stalls", 32'(stallVec), 32'hC);
        checkOutput("lw_flushes", 32'({flush_d, flush_e}), 32'h1);
        nextCycle();
        applyStimulus(1'b1, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lw_released", 32'({stall_f, flush_e}), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("lw_fwd_b_from_w", 32'(forward_b_e), 32'd1);
        idleCycles(3);

        // Branch with a load-use match present: the branch wins.
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("br_flushes", 32'({flush_d, flush_e}), 32'h3);
        checkOutput("br_no_stall", 32'({stall_f, stall_d}), 32'h0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("br_bubble_in_e", 32'({flush_d, flush_e}), 32'h0);
        idleCycles(3);

        // Memory wait: P, S (memory op), Q; ready low 3 cycles, branch held across the stall.
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(1'b1, 5'd1, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("mem_stall_c1", 32'(stallVec), 32'hF);
        checkOutput("mem_c1_commit", 32'(valid_w), 32'd1);
        nextCycle();
        applyIdleWithMem(1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("mem_stall_c2", 32'(stallVec), 32'hF);
        checkOutput("mem_c2_bubble", 32'(valid_w), 32'd0);
        checkOutput("mem_c2_no_flush", 32'({flush_d, flush_e}), 32'h0);
        nextCycle();
        applyIdleWithMem(1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("mem_stall_c3", 32'(stallVec), 32'hF);
        checkOutput("mem_c3_bubble", 32'(valid_w), 32'd0);
        nextCycle();
        applyIdleWithMem(1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("mem_ready_no_stall", 32'(stallVec), 32'h0);
        checkOutput("mem_branch_reasserts", 32'({flush_d, flush_e}), 32'h3);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("mem_m_advanced", 32'(valid_w), 32'd1);
        checkOutput("mem_run_again", 32'(stallVec), 32'h0);
        idleCycles(3);

        // Timeout: ready never arrives.
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b0, 1'b0);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("to_run_stall", 32'(stallVec), 32'hF);
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyIdleWithMem(1'b0, 1'b1, 1'b0);
        end
        nextCycle();
        applyIdleWithMem(1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("to_fourth_wait_no_err", 32'(mem_err), 32'd0);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("to_mem_err_set", 32'(mem_err), 32'd1);
        checkOutput("to_error_stalls", 32'(stallVec), 32'hF);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("to_error_ignores_ready", 32'(stallVec), 32'hF);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("to_mem_err_sticky", 32'(mem_err), 32'd1);

        // Reset out of ERROR takes effect without a clock edge.
        #1;
        reset = 1'b0;
        #1;
        checkOutput("err_reset_mem_err", 32'(mem_err), 32'd0);
        checkOutput("err_reset_stalls", 32'(stallVec), 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of WAIT.
        nextCycle();
        applyStimulus(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b0, 1'b0);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b1, 1'b0);
        nextCycle();
        applyIdleWithMem(1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("midwait_stalled", 32'(stall_m), 32'd1);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("midwait_reset_outputs", 32'(outVec), 32'd0);
        checkOutput("midwait_reset_mem_err", 32'(mem_err), 32'd0);
`ifdef PIPELINE_CTRL_PERF_EN
        checkOutput("midwait_reset_perf", stall_cycles | flush_count | retired_count, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        nextCycle();
        #1;
        checkOutput("midwait_back_in_run", 32'(stall_m), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
